ysyx_22040759_axi_bridge: RTL

// Single-beat AXI4 master serving the MEM stage's memory request port (mem_*). Converts one

---
 rtl/ysyx_22040759_axi_bridge_pkg.sv | 55 +++++
 rtl/ysyx_22040759_axi_bridge_lane.sv | 20 ++
 rtl/ysyx_22040759_axi_bridge.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040759_axi_bridge_pkg.sv
// Shared types, AXI encodings and lane helpers for the MEM-stage AXI bridge.
package ysyx_22040759_axi_bridge_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned STRB_W = DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [7:0] LEN_SINGLE  = 8'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AWW,
        ST_B,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic        store;
        logic [63:0] addr;
        logic [1:0]  size;
    } mem_req_t;

    // Natural alignment: low size bits of the address must be zero.
    function automatic logic misaligned(input logic [2:0] off, input logic [1:0] size);
        case (size)
            2'd0:    return 1'b0;
            2'd1:    return off[0];
            2'd2:    return |off[1:0];
            default: return |off;
        endcase
    endfunction

    function automatic logic [STRB_W-1:0] strb_base(input logic [1:0] size);
        case (size)
            2'd0:    return 8'h01;
            2'd1:    return 8'h03;
            2'd2:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] size_mask(input logic [1:0] size);
        case (size)
            2'd0:    return 64'h0000_0000_0000_00FF;
            2'd1:    return 64'h0000_0000_0000_FFFF;
            2'd2:    return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_22040759_axi_bridge_lane.sv
// Byte-lane steering: store strobe/data shift-up and load data shift-down with size mask.
module ysyx_22040759_axi_bridge_lane
    import ysyx_22040759_axi_bridge_pkg::*;
(
    input  logic [2:0]        wr_off,
    input  logic [1:0]        wr_size,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [2:0]        rd_off,
    input  logic [1:0]        rd_size,
    input  logic [DATA_W-1:0] rd_data,
    output logic [STRB_W-1:0] wstrb_c,
    output logic [DATA_W-1:0] wdata_c,
    output logic [DATA_W-1:0] rdata_c
);

    assign wstrb_c = strb_base(wr_size) << wr_off;
    assign wdata_c = wr_data << {wr_off, 3'b000};
    assign rdata_c = (rd_data >> {rd_off, 3'b000}) & size_mask(rd_size);

endmodule

// File: rtl/ysyx_22040759_axi_bridge.sv
// Single-beat AXI4 master for the MEM stage: one load/store per request, one outstanding.
module ysyx_22040759_axi_bridge
    import ysyx_22040759_axi_bridge_pkg::*;
#(
    parameter int unsigned AXI_AW = 32,
    parameter int unsigned ID_W   = 4,
    parameter int unsigned AXI_ID = 0
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              mem_valid,
    input  logic              mem_req,
    input  logic [63:0]       mem_addr,
    input  logic [1:0]        mem_size,
    input  logic [63:0]       mem_data_write,
    output logic              mem_ready,
    output logic [63:0]       mem_data_read,
    output logic [1:0]        mem_resp,

    output logic              axi_awvalid,
    input  logic              axi_awready,
    output logic [AXI_AW-1:0] axi_awaddr,
    output logic [ID_W-1:0]   axi_awid,
    output logic [7:0]        axi_awlen,
    output logic [2:0]        axi_awsize,
    output logic [1:0]        axi_awburst,

    output logic              axi_wvalid,
    input  logic              axi_wready,
    output logic [63:0]       axi_wdata,
    output logic [7:0]        axi_wstrb,
    output logic              axi_wlast,

    input  logic              axi_bvalid,
    output logic              axi_bready,
    input  logic [1:0]        axi_bresp,
    input  logic [ID_W-1:0]   axi_bid,

    output logic              axi_arvalid,
    input  logic              axi_arready,
    output logic [AXI_AW-1:0] axi_araddr,
    output logic [ID_W-1:0]   axi_arid,
    output logic [7:0]        axi_arlen,
    output logic [2:0]        axi_arsize,
    output logic [1:0]        axi_arburst,

    input  logic              axi_rvalid,
    output logic              axi_rready,
    input  logic [63:0]       axi_rdata,
    input  logic [1:0]        axi_rresp,
    input  logic              axi_rlast,
    input  logic [ID_W-1:0]   axi_rid
);

    state_t            state_q, state_d;
    mem_req_t          req_q, req_d;
    logic [DATA_W-1:0] wdata_d, data_read_d;
    logic [STRB_W-1:0] wstrb_d;
    logic [1:0]        resp_d;
    logic              arvalid_d, awvalid_d, wvalid_d, rready_d, bready_d, mem_ready_d;

    logic [STRB_W-1:0] lane_wstrb;
    logic [DATA_W-1:0] lane_wdata, lane_rdata;

    ysyx_22040759_axi_bridge_lane u_lane (
        .wr_off  (mem_addr[2:0]),
        .wr_size (mem_size),
        .wr_data (mem_data_write),
        .rd_off  (req_q.addr[2:0]),
        .rd_size (req_q.size),
        .rd_data (axi_rdata),
        .wstrb_c (lane_wstrb),
        .wdata_c (lane_wdata),
        .rdata_c (lane_rdata)
    );

    // Address/control fields come straight from the latched request.
    assign axi_araddr  = req_q.addr[AXI_AW-1:0];
    assign axi_awaddr  = req_q.addr[AXI_AW-1:0];
    assign axi_arsize  = {1'b0, req_q.size};
    assign axi_awsize  = {1'b0, req_q.size};
    assign axi_arid    = ID_W'(AXI_ID);
    assign axi_awid    = ID_W'(AXI_ID);
    assign axi_arlen   = LEN_SINGLE;
    assign axi_awlen   = LEN_SINGLE;
    assign axi_arburst = BURST_INCR;
    assign axi_awburst = BURST_INCR;
    assign axi_wlast   = 1'b1;

    logic unused_ok;
    assign unused_ok = ^{axi_rid, axi_bid, axi_rlast, req_q.addr};

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        wdata_d     = axi_wdata;
        wstrb_d     = axi_wstrb;
        arvalid_d   = axi_arvalid;
        awvalid_d   = axi_awvalid;
        wvalid_d    = axi_wvalid;
        rready_d    = axi_rready;
        bready_d    = axi_bready;
        mem_ready_d = 1'b0;
        data_read_d = mem_data_read;
        resp_d      = mem_resp;

        case (state_q)
            ST_IDLE: begin
                if (mem_valid) begin
                    req_d   = '{store: mem_req, addr: mem_addr, size: mem_size};
                    wdata_d = lane_wdata;
                    wstrb_d = lane_wstrb;
                    if (misaligned(mem_addr[2:0], mem_size)) begin
                        state_d     = ST_RESP;
                        mem_ready_d = 1'b1;
                        data_read_d = '0;
                        resp_d      = RESP_SLVERR;
                    end else if (mem_req) begin
                        state_d   = ST_AWW;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = ST_AR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            ST_AR: begin
                if (axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_R;
                end
            end
            ST_R: begin
                if (axi_rvalid) begin
                    rready_d    = 1'b0;
                    data_read_d = lane_rdata;
                    resp_d      = axi_rresp;
                    mem_ready_d = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_AWW: begin
                // A low valid doubles as the channel's done flag.
                if (axi_awready) awvalid_d = 1'b0;
                if (axi_wready)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = ST_B;
                end
            end
            ST_B: begin
                if (axi_bvalid) begin
                    bready_d    = 1'b0;
                    data_read_d = '0;
                    resp_d      = axi_bresp;
                    mem_ready_d = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            req_q         <= '0;
            axi_wdata     <= '0;
            axi_wstrb     <= '0;
            axi_arvalid   <= 1'b0;
            axi_awvalid   <= 1'b0;
            axi_wvalid    <= 1'b0;
            axi_rready    <= 1'b0;
            axi_bready    <= 1'b0;
            mem_ready     <= 1'b0;
            mem_data_read <= '0;
            mem_resp      <= RESP_OKAY;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            axi_wdata     <= wdata_d;
            axi_wstrb     <= wstrb_d;
            axi_arvalid   <= arvalid_d;
            axi_awvalid   <= awvalid_d;
            axi_wvalid    <= wvalid_d;
            axi_rready    <= rready_d;
            axi_bready    <= bready_d;
            mem_ready     <= mem_ready_d;
            mem_data_read <= data_read_d;
            mem_resp      <= resp_d;
        end
    end

endmodule
